// File: rtl/xcalc_pkg.sv
// Shared constants for the xcalc arithmetic peripheral: opcodes, FSM
// encoding, status bit positions and register addresses.
package xcalc_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, FINISH, DONE} state_t;

  localparam int BIT_BUSY = 0;
  localparam int BIT_DONE = 1;
  localparam int BIT_ERR  = 2;
  localparam int BIT_DROP = 3;

  localparam logic [1:0] ADDR_CMD = 2'd0;
  localparam logic [1:0] ADDR_RES = 2'd1;
  localparam logic [1:0] ADDR_REM = 2'd2;

endpackage

// File: rtl/xcalc_muldiv.sv
// Iterative unsigned multiplier / restoring divider on operand magnitudes.
// start loads the operands; NIB_W-1 iteration cycles follow. done is high
// during the cycle whose closing edge performs the final iteration, so the
// outputs are valid from the following cycle on and hold until next start.
module xcalc_muldiv #(
  parameter int NIB_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_div,
  input  logic [NIB_W-2:0]         a,
  input  logic [NIB_W-2:0]         b,
  output logic                     done,
  output logic [2*(NIB_W-1)-1:0]   prod,
  output logic [NIB_W-2:0]         quo,
  output logic [NIB_W-2:0]         rem
);
  localparam int M  = NIB_W - 1;
  localparam int CW = $clog2(M + 1);

  logic          run, div_mode;
  logic [CW-1:0] cnt;
  logic [2*M-1:0] acc, mcand;
  logic [M-1:0]  mplier, q, r, d;
  logic [M:0]    shifted, diff;
  logic          ge;

  // one restoring-division step: shift next dividend bit into the partial remainder
  always_comb begin
    shifted = {r, q[M-1]};
    diff    = shifted - {1'b0, d};
    ge      = (shifted >= {1'b0, d});
  end

  // operand load on start, then one shift-add or restore step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0; div_mode <= 1'b0; cnt <= '0;
      acc <= '0; mcand <= '0; mplier <= '0; q <= '0; r <= '0; d <= '0;
    end else if (start) begin
      run      <= 1'b1;
      div_mode <= is_div;
      cnt      <= CW'(M);
      acc      <= '0;
      mcand    <= {{M{1'b0}}, a};
      mplier   <= b;
      q        <= a;
      r        <= '0;
      d        <= b;
    end else if (run) begin
      if (div_mode) begin
        q <= {q[M-2:0], ge};
        r <= ge ? diff[M-1:0] : shifted[M-1:0];
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

  assign done = run && (cnt == CW'(1));
  assign prod = acc;
  assign quo  = q;
  assign rem  = r;

endmodule

// File: rtl/xcalc_engine.sv
// Memory-mapped signed arithmetic peripheral. One command word carries two
// sign-magnitude operands and an opcode; ADD/SUB run in one cycle, MUL/DIV
// iterate in xcalc_muldiv. Optional display outputs under XCALC_DISP_PORT_EN.
module xcalc_engine
  import xcalc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4,
  parameter int OP_W   = 4,
  parameter int RES_W  = 2 * NIB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
`ifdef XCALC_DISP_PORT_EN
  output logic [RES_W-1:0]  res_mag,
  output logic              res_neg,
`endif
  output logic              done
);
  localparam int M     = NIB_W - 1;
  localparam int CMD_W = OP_W + 2 * NIB_W;

  state_t state, nxt;

  logic [NIB_W-1:0] cmd_a, cmd_b;
  logic [OP_W-1:0]  op;
  logic             err, drop;
  logic             sa, sb;
  logic [RES_W-1:0] a_tc, b_tc, alu_q, result, remainder;
  logic [RES_W-1:0] fin_res, fin_rem, p_ext, q_ext, r_ext;
  logic             wr_cmd, accept, bad, is_md, md_start, md_done;
  logic [2*M-1:0]   md_prod;
  logic [M-1:0]     md_quo, md_rem;
  logic             unused_ok;

  assign unused_ok = ^data_in[DATA_W-1:CMD_W];

  assign wr_cmd = sel && we && (addr == ADDR_CMD);
  assign accept = wr_cmd && (state == IDLE || state == DONE);
  assign busy   = (state == DECODE) || (state == EXEC) || (state == FINISH);
  assign done   = (state == DONE);

  assign is_md    = (op == OP_W'(OP_MUL)) || (op == OP_W'(OP_DIV));
  assign bad      = (op > OP_W'(OP_DIV)) ||
                    ((op == OP_W'(OP_DIV)) && (cmd_b[M-1:0] == '0));
  assign md_start = (state == DECODE) && !bad && is_md;

  xcalc_muldiv #(.NIB_W(NIB_W)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .is_div(op == OP_W'(OP_DIV)),
    .a     (cmd_a[M-1:0]),
    .b     (cmd_b[M-1:0]),
    .done  (md_done),
    .prod  (md_prod),
    .quo   (md_quo),
    .rem   (md_rem)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state: error commands skip EXEC; MUL/DIV wait for the iterator
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (accept) nxt = DECODE;
      DECODE:     nxt = bad ? FINISH : EXEC;
      EXEC:       if (!is_md || md_done) nxt = FINISH;
      FINISH:     nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  // final signed values: quotient truncates toward zero, remainder follows dividend
  always_comb begin
    p_ext   = {{(RES_W-2*M){1'b0}}, md_prod};
    q_ext   = {{(RES_W-M){1'b0}}, md_quo};
    r_ext   = {{(RES_W-M){1'b0}}, md_rem};
    fin_res = '0;
    fin_rem = '0;
    if (!err) begin
      case (op)
        OP_W'(OP_ADD), OP_W'(OP_SUB): fin_res = alu_q;
        OP_W'(OP_MUL): fin_res = (sa ^ sb) ? -p_ext : p_ext;
        OP_W'(OP_DIV): begin
          fin_res = (sa ^ sb) ? -q_ext : q_ext;
          fin_rem = sa ? -r_ext : r_ext;
        end
        default: ;
      endcase
    end
  end

  // command capture, operand conversion, ALU and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_a <= '0; cmd_b <= '0; op <= '0;
      err <= 1'b0; drop <= 1'b0; sa <= 1'b0; sb <= 1'b0;
      a_tc <= '0; b_tc <= '0; alu_q <= '0;
      result <= '0; remainder <= '0;
`ifdef XCALC_DISP_PORT_EN
      res_mag <= '0; res_neg <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cmd_a <= data_in[NIB_W-1:0];
        cmd_b <= data_in[2*NIB_W-1:NIB_W];
        op    <= data_in[CMD_W-1:2*NIB_W];
        err   <= 1'b0;
        drop  <= 1'b0;
      end else if (wr_cmd && busy) begin
        drop <= 1'b1;
      end
      case (state)
        DECODE: begin
          // -0 collapses to +0: negating a zero magnitude is zero
          a_tc <= cmd_a[M] ? -RES_W'(cmd_a[M-1:0]) : RES_W'(cmd_a[M-1:0]);
          b_tc <= cmd_b[M] ? -RES_W'(cmd_b[M-1:0]) : RES_W'(cmd_b[M-1:0]);
          sa   <= cmd_a[M] && (cmd_a[M-1:0] != '0);
          sb   <= cmd_b[M] && (cmd_b[M-1:0] != '0);
          if (bad) err <= 1'b1;
        end
        EXEC: alu_q <= (op == OP_W'(OP_SUB)) ? a_tc - b_tc : a_tc + b_tc;
        FINISH: begin
          result    <= fin_res;
          remainder <= fin_rem;
`ifdef XCALC_DISP_PORT_EN
          res_mag   <= fin_res[RES_W-1] ? -fin_res : fin_res;
          res_neg   <= fin_res[RES_W-1];
`endif
        end
        default: ;
      endcase
    end
  end

  // bus read mux, results sign-extended to the bus width
  always_comb begin
    data_out = '0;
    if (sel) begin
      case (addr)
        ADDR_CMD: data_out = DATA_W'({drop, err, done, busy});
        ADDR_RES: data_out = {{(DATA_W-RES_W){result[RES_W-1]}}, result};
        ADDR_REM: data_out = {{(DATA_W-RES_W){remainder[RES_W-1]}}, remainder};
        default:  data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_xcalc_engine.sv
// Directed bench for xcalc_engine at default parameters (NIB_W=4, RES_W=8).
module tb_xcalc_engine;
  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic        busy, done;
`ifdef XCALC_DISP_PORT_EN
  logic [7:0]  res_mag;
  logic        res_neg;
`endif
  int checks = 0;
  int errors = 0;

  xcalc_engine dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .busy(busy),
`ifdef XCALC_DISP_PORT_EN
    .res_mag(res_mag), .res_neg(res_neg),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive a command so it is sampled at the next edge; return 1ns after it
  task automatic wr(input logic [31:0] v);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 2'd0; data_in = v;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 v = data_out;
    sel = 1'b0;
  endtask

  // done must stay low for n-1 edges after acceptance and rise on edge n
  task automatic wait_done(input string tag, input int n);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, "_early"}, {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(2'd0, v); chk("rst_status", v, 32'h0);
    rd(2'd1, v); chk("rst_result", v, 32'h0);
    rd(2'd2, v); chk("rst_rem", v, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sel = 1'b0; #1 chk("unsel_zero", data_out, 32'h0);

    // 3 + -5 = -2
    wr(32'h0D3);
    chk("add_busy", {31'd0, busy}, 32'd1);
    wait_done("add", 3);
    rd(2'd1, v); chk("add_result", v, 32'hFFFF_FFFE);
    rd(2'd0, v); chk("add_status", v, 32'h2);

    // -7 * -7 = 49
    wr(32'h2FF);
    wait_done("mul", 5);
    rd(2'd1, v); chk("mul_result", v, 32'h31);
    rd(2'd2, v); chk("mul_rem", v, 32'h0);

    // -7 / 2 = -3 rem -1
    wr(32'h32F);
    wait_done("div", 5);
    rd(2'd1, v); chk("div_result", v, 32'hFFFF_FFFD);
    rd(2'd2, v); chk("div_rem", v, 32'hFFFF_FFFF);
    rd(2'd0, v); chk("div_status", v, 32'h2);

    // 3 - 5 = -2 via SUB with positive b
    wr(32'h153);
    wait_done("sub", 3);
    rd(2'd1, v); chk("sub_result", v, 32'hFFFF_FFFE);

    // divide by zero
    wr(32'h305);
    wait_done("div0", 2);
    rd(2'd0, v); chk("div0_status", v, 32'h6);
    rd(2'd1, v); chk("div0_result", v, 32'h0);
    rd(2'd2, v); chk("div0_rem", v, 32'h0);

    // illegal opcode
    wr(32'h733);
    wait_done("ill", 2);
    rd(2'd0, v); chk("ill_status", v, 32'h6);
    rd(2'd1, v); chk("ill_result", v, 32'h0);

    // write during MUL is dropped
    wr(32'h2FF);                 // accepted at E0
    @(posedge clk); #1;          // E1
    wr(32'h0D3);                 // sampled at E2 while busy
    rd(2'd0, v); chk("drop_busy_status", v, 32'h9);
    repeat (2) begin @(posedge clk); #1; chk("drop_still_busy", {31'd0, done}, 32'd0); end
    @(posedge clk); #1;          // E5
    rd(2'd0, v); chk("drop_done_status", v, 32'hA);
    rd(2'd1, v); chk("drop_result", v, 32'h31);
    wr(32'h0D3);
    rd(2'd0, v); chk("drop_cleared", v, 32'h1);
    wait_done("after_drop", 3);
    rd(2'd1, v); chk("after_drop_result", v, 32'hFFFF_FFFE);

    // ignored writes to result register
    @(negedge clk); sel = 1'b1; we = 1'b1; addr = 2'd1; data_in = 32'h55;
    @(posedge clk); #1; sel = 1'b0; we = 1'b0;
    rd(2'd1, v); chk("res_write_ignored", v, 32'hFFFF_FFFE);

    // reset in the middle of a MUL
    wr(32'h2FF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(2'd0, v); chk("midrst_status", v, 32'h0);
    rd(2'd1, v); chk("midrst_result", v, 32'h0);
    repeat (5) @(posedge clk); #1;
    chk("midrst_no_done", {31'd0, done}, 32'd0);

    // -0 + 0 = 0
    wr(32'h008);
    wait_done("negzero", 3);
    rd(2'd1, v); chk("negzero_result", v, 32'h0);
    rd(2'd0, v); chk("negzero_status", v, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
